// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - multi-channel alarm comparator with ring, dismiss and snooze FSM
// Optional feature: define ALARM_SNOOZE_EN to build the snooze state and target registers.
module alarm_scheduler #(
  parameter int NUM_ALARMS = 4,
  parameter int IDXW       = 2,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            hour_rtc,
  input  logic [5:0]            min_rtc,
  input  logic [5:0]            sec_rtc,
  input  logic                  wr_en,
  input  logic [IDXW-1:0]       wr_idx,
  input  logic [4:0]            wr_hour,
  input  logic [5:0]            wr_min,
  input  logic [5:0]            wr_sec,
  input  logic                  wr_enable,
  input  logic                  dismiss,
  input  logic                  snooze,
  output logic                  alarm_active,
  output logic [IDXW-1:0]       active_idx,
  output logic                  snoozed,
  output logic [NUM_ALARMS-1:0] pending
);

  localparam logic [IDXW:0] NUM_A     = NUM_ALARMS[IDXW:0];
  localparam logic [7:0]    RING_LAST = 8'(RING_SECS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
`ifdef ALARM_SNOOZE_EN
    ST_SNOOZED = 2'd2,
`endif
    ST_RINGING = 2'd1
  } state_e;

  // Channel storage
  logic [4:0] ch_hour_q [NUM_ALARMS];
  logic [5:0] ch_min_q  [NUM_ALARMS];
  logic [5:0] ch_sec_q  [NUM_ALARMS];
  logic       ch_en_q   [NUM_ALARMS];

  logic [5:0]            prev_sec_q;
  logic [NUM_ALARMS-1:0] pending_q;
  state_e                state_q;
  logic [7:0]            ring_cnt_q;
  logic [IDXW-1:0]       active_idx_q;
  logic                  alarm_active_q;

  logic                  sec_edge;
  logic                  wr_ok;
  logic [NUM_ALARMS-1:0] match;
  logic [NUM_ALARMS-1:0] wr_clr;
  logic [NUM_ALARMS-1:0] svc_clr;
  logic [IDXW-1:0]       low_idx;
  logic                  take_pending;
  logic [7:0]            cnt_inc;

  assign sec_edge = (sec_rtc != prev_sec_q);
  assign wr_ok    = wr_en && ({1'b0, wr_idx} < NUM_A);
  assign cnt_inc  = ring_cnt_q + 8'd1;

`ifdef ALARM_SNOOZE_EN
  logic       snoozed_q;
  logic [4:0] tgt_hour_q;
  logic [5:0] tgt_min_q;
  logic [5:0] tgt_sec_q;
  logic [6:0] snz_min_sum;
  logic [4:0] snz_hour;
  logic [5:0] snz_min;
  logic       target_hit;

  // Snooze target: add minutes, carry into the hour, wrap the day at 24h
  always_comb begin
    snz_min_sum = {1'b0, min_rtc} + 7'(SNOOZE_MIN);
    snz_hour    = hour_rtc;
    snz_min     = snz_min_sum[5:0];
    if (snz_min_sum >= 7'd60) begin
      snz_min  = 6'(snz_min_sum - 7'd60);
      snz_hour = (hour_rtc == 5'd23) ? 5'd0 : hour_rtc + 5'd1;
    end
  end

  assign target_hit   = sec_edge && (hour_rtc == tgt_hour_q) &&
                        (min_rtc == tgt_min_q) && (sec_rtc == tgt_sec_q);
  assign take_pending = (|pending_q) &&
                        ((state_q == ST_IDLE) || ((state_q == ST_SNOOZED) && !dismiss));
  assign snoozed      = snoozed_q;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign take_pending  = (|pending_q) && (state_q == ST_IDLE);
  assign snoozed       = 1'b0;
`endif

  // Per-channel match on second edges against the stored (pre-write) times
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match[i] = sec_edge && ch_en_q[i] && (ch_hour_q[i] == hour_rtc) &&
                 (ch_min_q[i] == min_rtc) && (ch_sec_q[i] == sec_rtc);
    end
  end

  // Lowest-index pending channel wins service
  always_comb begin
    low_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IDXW'(i);
    end
  end

  // Pending bits cleared by a write to the channel or by being taken for service
  always_comb begin
    wr_clr  = '0;
    svc_clr = '0;
    if (wr_ok) wr_clr[wr_idx] = 1'b1;
    if (take_pending) svc_clr[low_idx] = 1'b1;
  end

  // Channel time/enable registers, written by the programming strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        ch_hour_q[i] <= '0;
        ch_min_q[i]  <= '0;
        ch_sec_q[i]  <= '0;
        ch_en_q[i]   <= 1'b0;
      end
    end else if (wr_ok) begin
      ch_hour_q[wr_idx] <= wr_hour;
      ch_min_q[wr_idx]  <= wr_min;
      ch_sec_q[wr_idx]  <= wr_sec;
      ch_en_q[wr_idx]   <= wr_enable;
    end
  end

  // Track the last seen RTC second to detect second edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_sec_q <= '0;
    else if (sec_edge) prev_sec_q <= sec_rtc;
  end

  // Pending set by matches; a same-cycle match survives a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else pending_q <= (pending_q & ~wr_clr & ~svc_clr) | match;
  end

  // Ringing FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ring_cnt_q     <= '0;
      active_idx_q   <= '0;
      alarm_active_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snoozed_q      <= 1'b0;
      tgt_hour_q     <= '0;
      tgt_min_q      <= '0;
      tgt_sec_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take_pending) begin
            state_q        <= ST_RINGING;
            active_idx_q   <= low_idx;
            ring_cnt_q     <= '0;
            alarm_active_q <= 1'b1;
          end
        end
        ST_RINGING: begin
          if (dismiss) begin
            state_q        <= ST_IDLE;
            alarm_active_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze) begin
            state_q        <= ST_SNOOZED;
            alarm_active_q <= 1'b0;
            snoozed_q      <= 1'b1;
            tgt_hour_q     <= snz_hour;
            tgt_min_q      <= snz_min;
            tgt_sec_q      <= sec_rtc;
`endif
          end else if (sec_edge) begin
            ring_cnt_q <= cnt_inc;
            if (cnt_inc == RING_LAST) begin
              state_q        <= ST_IDLE;
              alarm_active_q <= 1'b0;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZED: begin
          if (dismiss) begin
            state_q   <= ST_IDLE;
            snoozed_q <= 1'b0;
          end else if (take_pending) begin
            state_q        <= ST_RINGING;
            active_idx_q   <= low_idx;
            ring_cnt_q     <= '0;
            alarm_active_q <= 1'b1;
            snoozed_q      <= 1'b0;
          end else if (target_hit) begin
            state_q        <= ST_RINGING;
            ring_cnt_q     <= '0;
            alarm_active_q <= 1'b1;
            snoozed_q      <= 1'b0;
          end
        end
`endif
        default: begin
          state_q        <= ST_IDLE;
          alarm_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_active = alarm_active_q;
  assign active_idx   = active_idx_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb/tb_alarm_scheduler.sv - self-checking bench for alarm_scheduler with a seconds-of-day model
module tb_alarm_scheduler;
  localparam int NUM_ALARMS = 4;
  localparam int IDXW       = 2;
  localparam int RING_SECS  = 60;
  localparam int SNOOZE_MIN = 5;
  localparam int DAY        = 86400;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [4:0]            hour_rtc = '0;
  logic [5:0]            min_rtc = '0;
  logic [5:0]            sec_rtc = '0;
  logic                  wr_en = 1'b0;
  logic [IDXW-1:0]       wr_idx = '0;
  logic [4:0]            wr_hour = '0;
  logic [5:0]            wr_min = '0;
  logic [5:0]            wr_sec = '0;
  logic                  wr_enable = 1'b0;
  logic                  dismiss = 1'b0;
  logic                  snooze = 1'b0;
  logic                  alarm_active;
  logic [IDXW-1:0]       active_idx;
  logic                  snoozed;
  logic [NUM_ALARMS-1:0] pending;

  always #5 clk = ~clk;

  alarm_scheduler #(
    .NUM_ALARMS(NUM_ALARMS), .IDXW(IDXW), .RING_SECS(RING_SECS), .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hour_rtc(hour_rtc), .min_rtc(min_rtc), .sec_rtc(sec_rtc),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hour(wr_hour), .wr_min(wr_min), .wr_sec(wr_sec),
    .wr_enable(wr_enable), .dismiss(dismiss), .snooze(snooze),
    .alarm_active(alarm_active), .active_idx(active_idx), .snoozed(snoozed), .pending(pending)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: times as seconds-of-day; states 0 idle, 1 ringing, 2 snoozed
  int                    m_tod [NUM_ALARMS] = '{default: 0};
  bit                    m_en  [NUM_ALARMS] = '{default: 1'b0};
  bit [NUM_ALARMS-1:0]   m_pend = '0;
  int                    m_state = 0;
  int                    m_idx = 0;
  int                    m_cnt = 0;
  int                    m_target = 0;
  int                    m_prev_sec = 0;

  function automatic int lowest(input bit [NUM_ALARMS-1:0] p);
    for (int i = 0; i < NUM_ALARMS; i++) if (p[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int rtc;
    bit sedge;
    bit take;
    bit [NUM_ALARMS-1:0] nm;
    bit [NUM_ALARMS-1:0] clr;
    if (!rst_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        m_tod[i] = 0;
        m_en[i]  = 1'b0;
      end
      m_pend = '0; m_state = 0; m_idx = 0; m_cnt = 0; m_target = 0; m_prev_sec = 0;
    end else begin
      rtc   = int'(hour_rtc) * 3600 + int'(min_rtc) * 60 + int'(sec_rtc);
      sedge = (int'(sec_rtc) != m_prev_sec);
      nm    = '0;
      clr   = '0;
      take  = 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) if (sedge && m_en[i] && m_tod[i] == rtc) nm[i] = 1'b1;
      case (m_state)
        0: if (m_pend != 0) take = 1'b1;
        1: begin
          if (dismiss) m_state = 0;
          else if (SNZ && snooze) begin
            m_target = (rtc + SNOOZE_MIN * 60) % DAY;
            m_state  = 2;
          end else if (sedge) begin
            m_cnt++;
            if (m_cnt == RING_SECS) m_state = 0;
          end
        end
        default: begin
          if (dismiss) m_state = 0;
          else if (m_pend != 0) take = 1'b1;
          else if (sedge && rtc == m_target) begin
            m_state = 1;
            m_cnt   = 0;
          end
        end
      endcase
      if (take) begin
        m_idx = lowest(m_pend);
        clr[m_idx] = 1'b1;
        m_state = 1;
        m_cnt = 0;
      end
      if (wr_en && int'(wr_idx) < NUM_ALARMS) begin
        clr[wr_idx] = 1'b1;
        m_tod[wr_idx] = int'(wr_hour) * 3600 + int'(wr_min) * 60 + int'(wr_sec);
        m_en[wr_idx]  = wr_enable;
      end
      m_pend = (m_pend & ~clr) | nm;
      m_prev_sec = int'(sec_rtc);
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_pending", pending, m_pend);
      check("cyc_alarm_active", alarm_active, m_state == 1);
      check("cyc_snoozed", snoozed, m_state == 2);
      if (m_state != 0) check("cyc_active_idx", active_idx, m_idx);
    end
  end

  int cur_tod = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tod(input int t);
    cur_tod  = t % DAY;
    hour_rtc = 5'(cur_tod / 3600);
    min_rtc  = 6'((cur_tod / 60) % 60);
    sec_rtc  = 6'(cur_tod % 60);
  endtask

  task automatic set_tod(input int t);
    drive_tod(t);
    step();
  endtask

  task automatic program_ch(input int idx, input int t, input bit en);
    wr_en = 1'b1;
    wr_idx = IDXW'(idx);
    wr_hour = 5'(t / 3600);
    wr_min = 6'((t / 60) % 60);
    wr_sec = 6'(t % 60);
    wr_enable = en;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse(input bit d, input bit s);
    dismiss = d;
    snooze = s;
    step();
    dismiss = 1'b0;
    snooze = 1'b0;
  endtask

  function automatic int hms(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  initial begin
    repeat (2) step();
    check("reset_alarm_active", alarm_active, 0);
    check("reset_active_idx", active_idx, 0);
    check("reset_snoozed", snoozed, 0);
    check("reset_pending", pending, 0);
    rst_n = 1'b1;
    step();

    // Single alarm: match, ring, auto-silence after RING_SECS second edges
    program_ch(1, hms(7, 30, 0), 1'b1);
    set_tod(hms(7, 29, 59));
    set_tod(hms(7, 30, 0));
    check("t1_pending", pending, 4'b0010);
    step();
    check("t1_alarm_on", alarm_active, 1);
    check("t1_idx", active_idx, 1);
    for (int k = 1; k <= RING_SECS; k++) begin
      set_tod(hms(7, 30, 0) + k);
      if (k == RING_SECS - 1) check("t1_still_ringing", alarm_active, 1);
    end
    check("t1_auto_silence", alarm_active, 0);

    // Two simultaneous matches serviced in index order
    program_ch(0, hms(12, 0, 0), 1'b1);
    program_ch(2, hms(12, 0, 0), 1'b1);
    set_tod(hms(11, 59, 59));
    set_tod(hms(12, 0, 0));
    check("t2_pending", pending, 4'b0101);
    check("t2_model_pending", m_pend, 4'b0101);
    step();
    check("t2_ch0_ring", alarm_active, 1);
    check("t2_ch0_idx", active_idx, 0);
    check("t2_pending_left", pending, 4'b0100);
    pulse(1'b1, 1'b0);
    check("t2_dismissed", alarm_active, 0);
    step();
    check("t2_ch2_ring", alarm_active, 1);
    check("t2_ch2_idx", active_idx, 2);
    pulse(1'b1, 1'b0);
    check("t2_done", alarm_active, 0);

    // Snooze across midnight
    program_ch(3, hms(23, 58, 10), 1'b1);
    set_tod(hms(23, 58, 9));
    set_tod(hms(23, 58, 10));
    step();
    check("t3_ring", alarm_active, 1);
    check("t3_idx", active_idx, 3);
    pulse(1'b0, 1'b1);
`ifdef ALARM_SNOOZE_EN
    check("t3_snoozed", snoozed, 1);
    check("t3_silent", alarm_active, 0);
    check("t3_model_target", m_target, hms(0, 3, 10));
    set_tod(hms(0, 3, 9));
    check("t3_still_snoozed", snoozed, 1);
    set_tod(hms(0, 3, 10));
    check("t3_rering", alarm_active, 1);
    check("t3_rering_idx", active_idx, 3);
    check("t3_unsnoozed", snoozed, 0);
`else
    check("t3_snooze_ignored", alarm_active, 1);
    check("t3_snoozed_tied", snoozed, 0);
`endif
    pulse(1'b1, 1'b0);
    check("t3_dismissed", alarm_active, 0);

    // Disabled channel never pends; strobes in IDLE do nothing
    program_ch(0, hms(5, 0, 0), 1'b0);
    set_tod(hms(4, 59, 59));
    set_tod(hms(5, 0, 0));
    check("t4_no_pending", pending, 0);
    step();
    check("t4_no_ring", alarm_active, 0);
    pulse(1'b1, 1'b1);
    check("t4_idle_alarm", alarm_active, 0);
    check("t4_idle_snoozed", snoozed, 0);

    // Asynchronous reset mid-ring
    set_tod(hms(7, 29, 59));
    set_tod(hms(7, 30, 0));
    step();
    check("t5_ring", alarm_active, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_alarm", alarm_active, 0);
    check("t5_rst_pending", pending, 0);
    check("t5_rst_snoozed", snoozed, 0);
    check("t5_rst_idx", active_idx, 0);
    step();
    rst_n = 1'b1;
    step();

    // Dismiss and snooze together: dismiss wins
    program_ch(1, hms(7, 30, 0), 1'b1);
    set_tod(hms(7, 29, 59));
    set_tod(hms(7, 30, 0));
    step();
    check("t6_ring", alarm_active, 1);
    pulse(1'b1, 1'b1);
    check("t6_alarm_off", alarm_active, 0);
    check("t6_not_snoozed", snoozed, 0);
    step();
    check("t6_stays_idle", snoozed, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 45) drive_tod(cur_tod + 1);
      else if (r < 47) drive_tod(int'($urandom_range(0, DAY - 1)));
      if ($urandom_range(0, 99) < 4) begin
        int t;
        t = (cur_tod + int'($urandom_range(0, 25))) % DAY;
        wr_en = 1'b1;
        wr_idx = IDXW'($urandom_range(0, NUM_ALARMS - 1));
        wr_hour = 5'(t / 3600);
        wr_min = 6'((t / 60) % 60);
        wr_sec = 6'(t % 60);
        wr_enable = ($urandom_range(0, 3) != 0);
      end else begin
        wr_en = 1'b0;
      end
      dismiss = ($urandom_range(0, 99) < 2);
      snooze = ($urandom_range(0, 99) < 3);
      step();
    end
    wr_en = 1'b0;
    dismiss = 1'b0;
    snooze = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
